// File: rtl/apr_err_intr_ctl_pkg.sv
// -----------------------------------------------------------------------------
// apr_pkg
//   Shared types for the APR error-flag / interrupt controller.
//   cono_op_e  : CONO operation applied to the mask bits.
//   pi_state_e : states of the priority-interrupt request FSM.
// -----------------------------------------------------------------------------
package apr_pkg;

  typedef enum logic [1:0] {
    SET_FLG = 2'b00,
    CLR_FLG = 2'b01,
    SET_EN  = 2'b10,
    CLR_EN  = 2'b11
  } cono_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_CLR = 2'b10
  } pi_state_e;

endpackage

// File: rtl/apr_err_intr_ctl_if.sv
// -----------------------------------------------------------------------------
// apr_err_intr_ctl_if
//   EBOX-side bus of the APR error controller: CONO commands, PIA load,
//   PI request/grant handshake and CONI read handshake.
//   master : the EBOX / PI system side (drives commands, grant, CONI request)
//   slave  : the controller (drives CONI data/ack, PI request and level)
// -----------------------------------------------------------------------------
import apr_pkg::*;

interface apr_err_intr_ctl_if #(
  parameter int NFLAGS = 8,
  parameter int PIA_W  = 3
);
  logic                      cono_valid_h;
  cono_op_e                  cono_op_h;
  logic [NFLAGS-1:0]         cono_mask_h;
  logic                      pia_load_h;
  logic [PIA_W-1:0]          pia_h;
  logic                      pi_grant_h;
  logic                      coni_req_h;
  logic                      coni_ack_h;
  logic [2*NFLAGS+PIA_W-1:0] coni_data_h;
  logic                      pi_req_h;
  logic [PIA_W-1:0]          pi_level_h;

  modport master (
    output cono_valid_h, cono_op_h, cono_mask_h, pia_load_h, pia_h,
           pi_grant_h, coni_req_h,
    input  coni_ack_h, coni_data_h, pi_req_h, pi_level_h
  );

  modport slave (
    input  cono_valid_h, cono_op_h, cono_mask_h, pia_load_h, pia_h,
           pi_grant_h, coni_req_h,
    output coni_ack_h, coni_data_h, pi_req_h, pi_level_h
  );
endinterface

// File: rtl/apr_err_intr_ctl_pi_req_fsm.sv
// -----------------------------------------------------------------------------
// apr_pi_req_fsm
//   PI request sequencer. Requests while an enabled flag is pending, drops the
//   request after a grant and re-requests when a new enabled flag sets.
//   clk, rst_n : clock, asynchronous active-low reset
//   pend       : enabled flag pending and PIA non-zero
//   new_flg    : a newly set enabled flag this cycle
//   grant      : PI system accepted the request (ignored outside REQ)
//   pi_req     : request output, high only in REQ
// -----------------------------------------------------------------------------
import apr_pkg::*;

module apr_pi_req_fsm (
  input  logic clk,
  input  logic rst_n,
  input  logic pend,
  input  logic new_flg,
  input  logic grant,
  output logic pi_req
);

  pi_state_e state, state_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pi_req  = 1'b0;
    case (state)
      IDLE: begin
        if (pend) state_n = REQ;
      end
      REQ: begin
        pi_req = 1'b1;
        // Losing the pending condition outranks a coincident grant.
        if (!pend)      state_n = IDLE;
        else if (grant) state_n = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!pend)        state_n = IDLE;
        else if (new_flg) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/apr_err_intr_ctl.sv
// -----------------------------------------------------------------------------
// apr_err_intr_ctl
//   APR error-flag and interrupt controller. Latches active-low error sources
//   into sticky flags, masks them with enables, raises a PI request at the
//   programmed PIA level and serves CONI snapshots with a one-cycle ack.
//   clk3_apr_h      : APR clock
//   mr_reset_l      : asynchronous active-low master reset
//   err_in_l        : active-low error sources, sampled every clock
//   bus             : CONO / PIA / PI / CONI bus (slave side)
//   apr_interrupt_l : low while an enabled flag is pending and PIA != 0
//   any_err_flg_h   : OR of all flags
//   first_err_h     : one-hot first flag set since flags were last all-zero
// -----------------------------------------------------------------------------
import apr_pkg::*;

module apr_err_intr_ctl #(
  parameter int NFLAGS = 8,
  parameter int PIA_W  = 3
) (
  input  logic                    clk3_apr_h,
  input  logic                    mr_reset_l,
  input  logic [NFLAGS-1:0]       err_in_l,
  apr_err_intr_ctl_if.slave       bus,
  output logic                    apr_interrupt_l,
  output logic                    any_err_flg_h,
  output logic [NFLAGS-1:0]       first_err_h
);

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [NFLAGS-1:0] lowest_bit(input logic [NFLAGS-1:0] v);
    return v & (~v + 1'b1);
  endfunction

  logic [NFLAGS-1:0] flags, enables, set, clr, flags_n;
  logic [PIA_W-1:0]  pia;
  logic              pend, new_flg, pi_req;

  always_comb begin
    set = ~err_in_l;
    clr = '0;
    if (bus.cono_valid_h) begin
      case (bus.cono_op_h)
        SET_FLG: set = set | bus.cono_mask_h;
        CLR_FLG: clr = bus.cono_mask_h;
        default: ;
      endcase
    end
    // Set is applied after clear so a coincident error is never lost.
    flags_n = (flags & ~clr) | set;
  end

  assign pend    = (|(flags & enables)) && (pia != '0);
  assign new_flg = |(set & ~flags & enables);

  always_ff @(posedge clk3_apr_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      flags           <= '0;
      enables         <= '0;
      pia             <= '0;
      first_err_h     <= '0;
      apr_interrupt_l <= 1'b1;
      bus.coni_ack_h  <= 1'b0;
      bus.coni_data_h <= '0;
    end else begin
      flags <= flags_n;

      if (bus.cono_valid_h && bus.cono_op_h == SET_EN)
        enables <= enables | bus.cono_mask_h;
      else if (bus.cono_valid_h && bus.cono_op_h == CLR_EN)
        enables <= enables & ~bus.cono_mask_h;

      if (bus.pia_load_h) pia <= bus.pia_h;

      if (flags == '0 && set != '0) first_err_h <= lowest_bit(set);
      else if (flags_n == '0)       first_err_h <= '0;

      apr_interrupt_l <= ~pend;

      // Snapshot uses the register values before this cycle's update.
      bus.coni_ack_h <= bus.coni_req_h;
      if (bus.coni_req_h) bus.coni_data_h <= {enables, flags, pia};
    end
  end

  assign any_err_flg_h  = |flags;
  assign bus.pi_level_h = pia;
  assign bus.pi_req_h   = pi_req;

  apr_pi_req_fsm u_pi_req_fsm (
    .clk     (clk3_apr_h),
    .rst_n   (mr_reset_l),
    .pend    (pend),
    .new_flg (new_flg),
    .grant   (bus.pi_grant_h),
    .pi_req  (pi_req)
  );

endmodule
